// File: rtl/rgs_pkg.sv
// Shared opcode and FSM state encodings for ray_gen_sequencer.
// Also holds the instruction field offsets, derived from the register-field width.
package rgs_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_DIV  = 4'd4,
        OP_PUSH = 4'd5,
        OP_JNZ  = 4'd6
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_DIVW  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Instruction layout, MSB first: {stop, op[3:0], dst, srcA, srcB}
    function automatic int insn_width(input int rf_aw);
        return 5 + 3 * rf_aw;
    endfunction

    function automatic int srcb_lsb(input int rf_aw);
        return 0 * rf_aw;
    endfunction

    function automatic int srca_lsb(input int rf_aw);
        return rf_aw;
    endfunction

    function automatic int dst_lsb(input int rf_aw);
        return 2 * rf_aw;
    endfunction

    function automatic int op_lsb(input int rf_aw);
        return 3 * rf_aw;
    endfunction

    function automatic int stop_bit(input int rf_aw);
        return 3 * rf_aw + 4;
    endfunction

endpackage

// File: rtl/rgs_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done_o marks the final step.
// Compiled only when RGS_DIV_EN is defined.
`ifdef RGS_DIV_EN
module rgs_seq_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   rem_step;
    logic [DATA_W-1:0] quot_step;

    // Last step is used combinationally so the quotient lands after exactly DATA_W cycles
    always_comb begin
        rem_shift = {rem_q[DATA_W-1:0], quot_q[DATA_W-1]};
        diff      = rem_shift - {1'b0, divisor_q};
        rem_step  = diff[DATA_W] ? rem_shift : diff;
        quot_step = {quot_q[DATA_W-2:0], ~diff[DATA_W]};
    end

    always_comb begin
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        count_d   = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (start_i) begin
            rem_d     = '0;
            quot_d    = dividend_i;
            divisor_d = divisor_i;
            count_d   = CNT_W'(DATA_W);
        end else if (count_q != '0) begin
            rem_d   = rem_step;
            quot_d  = quot_step;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            count_q   <= '0;
        end else begin
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            count_q   <= count_d;
        end
    end

    assign done_o     = (count_q == CNT_W'(1));
    assign quotient_o = quot_step;

endmodule
`endif

// File: rtl/ray_gen_sequencer.sv
// Micro-sequencer: host-loaded instruction RAM and register file, FETCH/EXEC loop, FIFO push.
// Define RGS_DIV_EN to add the multi-cycle DIV instruction (rgs_seq_divider).
module ray_gen_sequencer
    import rgs_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int INSN_DEPTH = 32,
    parameter int RF_DEPTH   = 32
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iEnable,
    output logic              oBusy,
    output logic              oDone,
    output logic              oFifoPush,
    output logic [DATA_W-1:0] oFifoData,
    input  logic              iFifoFull,
    input  logic              iUartSelected,
    input  logic              iUartWrite,
    input  logic [7:0]        iUartAddr,
    input  logic [DATA_W-1:0] iUartData,
    output logic [DATA_W-1:0] oUartData
);
    localparam int RF_AW    = $clog2(RF_DEPTH);
    localparam int IP_W     = $clog2(INSN_DEPTH);
    localparam int INSN_W   = insn_width(RF_AW);
    localparam int OP_LSB   = op_lsb(RF_AW);
    localparam int DST_LSB  = dst_lsb(RF_AW);
    localparam int SRCA_LSB = srca_lsb(RF_AW);
    localparam int SRCB_LSB = srcb_lsb(RF_AW);
    localparam int STOP_BIT = stop_bit(RF_AW);

    logic [INSN_W-1:0] insn_mem [INSN_DEPTH];
    logic [DATA_W-1:0] rf_mem   [RF_DEPTH];

    state_e            state_q, state_d;
    logic [IP_W-1:0]   ip_q, ip_d;
    logic [INSN_W-1:0] insn_q, insn_d;

    logic [3:0]        op;
    logic [RF_AW-1:0]  dst, src_a, src_b;
    logic              stop;
    logic [DATA_W-1:0] op_a, op_b;
    logic [IP_W-1:0]   next_ip;
    logic              retire;
    logic              host_wr;
    logic              insn_we;
    logic              rf_we;
    logic [RF_AW-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              unused_addr_bits;

    assign op    = insn_q[OP_LSB +: 4];
    assign dst   = insn_q[DST_LSB +: RF_AW];
    assign src_a = insn_q[SRCA_LSB +: RF_AW];
    assign src_b = insn_q[SRCB_LSB +: RF_AW];
    assign stop  = insn_q[STOP_BIT];
    assign op_a  = rf_mem[src_a];
    assign op_b  = rf_mem[src_b];

    assign host_wr          = (state_q == ST_IDLE) && iUartSelected && iUartWrite;
    assign insn_we          = host_wr && iUartAddr[7];
    assign unused_addr_bits = ^iUartAddr;

`ifdef RGS_DIV_EN
    logic              div_start;
    logic              div_clear;
    logic              div_done;
    logic [DATA_W-1:0] div_quot;

    rgs_seq_divider #(
        .DATA_W(DATA_W)
    ) u_div (
        .clk       (iClock),
        .rst_n     (iReset),
        .start_i   (div_start),
        .clear_i   (div_clear),
        .dividend_i(op_a),
        .divisor_i (op_b),
        .done_o    (div_done),
        .quotient_o(div_quot)
    );
`endif

    // Losing iEnable while running drops the in-flight write/push and returns to IDLE
    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        insn_d    = insn_q;
        rf_we     = 1'b0;
        rf_waddr  = iUartAddr[RF_AW-1:0];
        rf_wdata  = iUartData;
        oFifoPush = 1'b0;
        retire    = 1'b0;
`ifdef RGS_DIV_EN
        div_start = 1'b0;
        div_clear = 1'b0;
`endif
        next_ip = ip_q + IP_W'(1);
        if (op == OP_JNZ && op_a != '0) begin
            next_ip = IP_W'(src_b);
        end

        case (state_q)
            ST_IDLE: begin
                rf_we = host_wr && !iUartAddr[7];
                if (iEnable) begin
                    state_d = ST_FETCH;
                    ip_d    = '0;
                end
            end
            ST_FETCH: begin
                if (!iEnable) begin
                    state_d = ST_IDLE;
                end else begin
                    insn_d  = insn_mem[ip_q];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!iEnable) begin
                    state_d = ST_IDLE;
                end else begin
                    retire = 1'b1;
                    case (op)
                        OP_ADD: begin
                            rf_we    = 1'b1;
                            rf_waddr = dst;
                            rf_wdata = op_a + op_b;
                        end
                        OP_SUB: begin
                            rf_we    = 1'b1;
                            rf_waddr = dst;
                            rf_wdata = op_a - op_b;
                        end
                        OP_MUL: begin
                            rf_we    = 1'b1;
                            rf_waddr = dst;
                            rf_wdata = op_a * op_b;
                        end
                        OP_PUSH: begin
                            if (iFifoFull) begin
                                retire = 1'b0;
                            end else begin
                                oFifoPush = 1'b1;
                            end
                        end
`ifdef RGS_DIV_EN
                        OP_DIV: begin
                            retire    = 1'b0;
                            div_start = 1'b1;
                            state_d   = ST_DIVW;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_DIVW: begin
`ifdef RGS_DIV_EN
                if (!iEnable) begin
                    state_d   = ST_IDLE;
                    div_clear = 1'b1;
                end else if (div_done) begin
                    retire   = 1'b1;
                    rf_we    = 1'b1;
                    rf_waddr = dst;
                    rf_wdata = div_quot;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (!iEnable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire) begin
            ip_d    = next_ip;
            state_d = stop ? ST_DONE : ST_FETCH;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
            ip_q    <= '0;
            insn_q  <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            insn_q  <= insn_d;
        end
    end

    // Storage has no reset so a program survives a reset or abort
    always_ff @(posedge iClock) begin
        if (insn_we) begin
            insn_mem[iUartAddr[IP_W-1:0]] <= iUartData[INSN_W-1:0];
        end
        if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        oUartData = '0;
        if (state_q == ST_IDLE || state_q == ST_DONE) begin
            oUartData = iUartAddr[7] ? DATA_W'(insn_mem[iUartAddr[IP_W-1:0]])
                                     : rf_mem[iUartAddr[RF_AW-1:0]];
        end
    end

    assign oBusy     = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_DIVW);
    assign oDone     = (state_q == ST_DONE);
    assign oFifoData = op_a;

endmodule

// File: tb/tb_ray_gen_sequencer.sv
// Directed self-checking bench for ray_gen_sequencer (default parameters).
// Expectations adapt to whether RGS_DIV_EN is defined for the build.
module tb_ray_gen_sequencer;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] ADD  = 4'd1;
    localparam logic [3:0] SUB  = 4'd2;
    localparam logic [3:0] MUL  = 4'd3;
    localparam logic [3:0] DIV  = 4'd4;
    localparam logic [3:0] PUSH = 4'd5;
    localparam logic [3:0] JNZ  = 4'd6;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iEnable = 1'b0;
    logic        iFifoFull = 1'b0;
    logic        iUartSelected = 1'b0;
    logic        iUartWrite = 1'b0;
    logic [7:0]  iUartAddr = 8'h00;
    logic [31:0] iUartData = 32'h0;
    logic        oBusy;
    logic        oDone;
    logic        oFifoPush;
    logic [31:0] oFifoData;
    logic [31:0] oUartData;

    int          checkCount = 0;
    int          passCount = 0;
    logic [31:0] pushLog[$];
    logic [31:0] rd;

    ray_gen_sequencer dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iEnable      (iEnable),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oFifoPush    (oFifoPush),
        .oFifoData    (oFifoData),
        .iFifoFull    (iFifoFull),
        .iUartSelected(iUartSelected),
        .iUartWrite   (iUartWrite),
        .iUartAddr    (iUartAddr),
        .iUartData    (iUartData),
        .oUartData    (oUartData)
    );

    always #5 iClock = ~iClock;

    // Record every push strobe mid-cycle, away from the rising edge
    always @(negedge iClock) begin
        if (oFifoPush) pushLog.push_back(oFifoData);
    end

    function automatic logic [31:0] enc(input logic stop, input logic [3:0] op,
                                        input logic [4:0] d, input logic [4:0] a,
                                        input logic [4:0] b);
        return {12'd0, stop, op, d, a, b};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, expected);
    endtask

    // Host write of one location; only takes effect while the sequencer is idle
    task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
        iUartSelected = 1'b1;
        iUartWrite    = 1'b1;
        iUartAddr     = addr;
        iUartData     = data;
        @(posedge iClock);
        #1;
        iUartSelected = 1'b0;
        iUartWrite    = 1'b0;
    endtask

    task automatic readHost(input logic [7:0] addr, output logic [31:0] data);
        iUartAddr = addr;
        #1;
        data = oUartData;
    endtask

    task automatic idleCycle();
        iEnable = 1'b0;
        @(posedge iClock);
        #1;
    endtask

    task automatic runUntilDone(input string tag, input int expCycles);
        int cycles;
        cycles  = 0;
        iEnable = 1'b1;
        while (!oDone && cycles < 200) begin
            @(posedge iClock);
            #1;
            cycles++;
        end
        checkOutput({tag, "_done"}, {31'd0, oDone}, 32'd1);
        checkOutput({tag, "_cycles"}, cycles, expCycles);
    endtask

    initial begin
        #12;
        checkOutput("rst_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("rst_done", {31'd0, oDone}, 32'd0);
        checkOutput("rst_push", {31'd0, oFifoPush}, 32'd0);
        @(posedge iClock);
        #1;
        iReset = 1'b1;
        @(posedge iClock);
        #1;

        // ADD r3,r1,r2 with stop: FETCH, EXEC, then DONE
        applyStimulus(8'h01, 32'd7);
        applyStimulus(8'h02, 32'd5);
        applyStimulus(8'h80, enc(1'b1, ADD, 5'd3, 5'd1, 5'd2));
        readHost(8'h01, rd);
        checkOutput("host_rd_r1", rd, 32'd7);
        iEnable = 1'b1;
        @(posedge iClock); #1;
        checkOutput("add_fetch_busy", {31'd0, oBusy}, 32'd1);
        checkOutput("add_fetch_done", {31'd0, oDone}, 32'd0);
        @(posedge iClock); #1;
        checkOutput("add_exec_done", {31'd0, oDone}, 32'd0);
        @(posedge iClock); #1;
        checkOutput("add_done", {31'd0, oDone}, 32'd1);
        checkOutput("add_done_busy", {31'd0, oBusy}, 32'd0);
        readHost(8'h03, rd);
        checkOutput("add_r3", rd, 32'd12);
        applyStimulus(8'h01, 32'd99);
        idleCycle();
        checkOutput("idle_after_done", {31'd0, oDone}, 32'd0);
        readHost(8'h01, rd);
        checkOutput("write_in_done_ignored", rd, 32'd7);

        // SUB wraps below zero, MUL keeps only the low word
        applyStimulus(8'h06, 32'h0001_0000);
        applyStimulus(8'h07, 32'h0000_0055);
        applyStimulus(8'h80, enc(1'b0, SUB, 5'd3, 5'd2, 5'd1));
        applyStimulus(8'h81, enc(1'b1, MUL, 5'd7, 5'd6, 5'd6));
        runUntilDone("submul", 5);
        readHost(8'h03, rd);
        checkOutput("sub_wrap", rd, 32'hFFFF_FFFE);
        readHost(8'h07, rd);
        checkOutput("mul_wrap", rd, 32'h0);
        idleCycle();

        // PUSH held off by a full FIFO for 3 cycles, then exactly one push
        applyStimulus(8'h80, enc(1'b1, PUSH, 5'd0, 5'd1, 5'd0));
        pushLog.delete();
        iFifoFull = 1'b1;
        iEnable   = 1'b1;
        @(posedge iClock); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge iClock); #1;
            checkOutput($sformatf("push_stall%0d", i), {31'd0, oFifoPush}, 32'd0);
        end
        readHost(8'h01, rd);
        checkOutput("uart_busy_zero", rd, 32'h0);
        iFifoFull = 1'b0;
        #1;
        checkOutput("push_strobe", {31'd0, oFifoPush}, 32'd1);
        checkOutput("push_data", oFifoData, 32'd7);
        @(posedge iClock); #1;
        checkOutput("push_done", {31'd0, oDone}, 32'd1);
        checkOutput("push_count", pushLog.size(), 32'd1);
        idleCycle();

        // Count-down loop: pushes 2,1,0 then stops on the NOP
        applyStimulus(8'h04, 32'd3);
        applyStimulus(8'h05, 32'd1);
        applyStimulus(8'h80, enc(1'b0, SUB, 5'd4, 5'd4, 5'd5));
        applyStimulus(8'h81, enc(1'b0, PUSH, 5'd0, 5'd4, 5'd0));
        applyStimulus(8'h82, enc(1'b0, JNZ, 5'd0, 5'd4, 5'd0));
        applyStimulus(8'h83, enc(1'b1, NOP, 5'd0, 5'd0, 5'd0));
        pushLog.delete();
        runUntilDone("loop", 21);
        checkOutput("loop_npush", pushLog.size(), 32'd3);
        if (pushLog.size() == 3) begin
            checkOutput("loop_push0", pushLog[0], 32'd2);
            checkOutput("loop_push1", pushLog[1], 32'd1);
            checkOutput("loop_push2", pushLog[2], 32'd0);
        end
        idleCycle();

        // DIV 100/7 and 5/0
        applyStimulus(8'h08, 32'd100);
        applyStimulus(8'h09, 32'd7);
        applyStimulus(8'h0A, 32'h0000_1234);
        applyStimulus(8'h80, enc(1'b1, DIV, 5'd10, 5'd8, 5'd9));
`ifdef RGS_DIV_EN
        runUntilDone("div", 35);
        readHost(8'h0A, rd);
        checkOutput("div_quot", rd, 32'd14);
`else
        runUntilDone("div", 3);
        readHost(8'h0A, rd);
        checkOutput("div_nop", rd, 32'h0000_1234);
`endif
        idleCycle();
        applyStimulus(8'h0B, 32'd5);
        applyStimulus(8'h00, 32'd0);
        applyStimulus(8'h0C, 32'h0000_ABCD);
        applyStimulus(8'h80, enc(1'b1, DIV, 5'd12, 5'd11, 5'd0));
`ifdef RGS_DIV_EN
        runUntilDone("div0", 35);
        readHost(8'h0C, rd);
        checkOutput("div0_quot", rd, 32'hFFFF_FFFF);
`else
        runUntilDone("div0", 3);
        readHost(8'h0C, rd);
        checkOutput("div0_nop", rd, 32'h0000_ABCD);
`endif
        idleCycle();

        // Drop iEnable during a PUSH stall: no push, back to IDLE, RAM kept
        applyStimulus(8'h80, enc(1'b1, PUSH, 5'd0, 5'd1, 5'd0));
        pushLog.delete();
        iFifoFull = 1'b1;
        iEnable   = 1'b1;
        repeat (4) begin
            @(posedge iClock); #1;
        end
        iEnable   = 1'b0;
        iFifoFull = 1'b0;
        #1;
        checkOutput("abort_push_strobe", {31'd0, oFifoPush}, 32'd0);
        @(posedge iClock); #1;
        checkOutput("abort_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("abort_done", {31'd0, oDone}, 32'd0);
        checkOutput("abort_npush", pushLog.size(), 32'd0);
        readHost(8'h80, rd);
        checkOutput("abort_ram", rd, enc(1'b1, PUSH, 5'd0, 5'd1, 5'd0));

        // Reset in the middle of a division, then rerun from a clean divider
        applyStimulus(8'h0D, 32'h0000_0077);
        applyStimulus(8'h80, enc(1'b0, DIV, 5'd13, 5'd8, 5'd9));
        applyStimulus(8'h81, enc(1'b1, NOP, 5'd0, 5'd0, 5'd0));
        iEnable = 1'b1;
        repeat (10) begin
            @(posedge iClock); #1;
        end
        iEnable = 1'b0;
        iReset  = 1'b0;
        #1;
        checkOutput("rst_mid_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("rst_mid_done", {31'd0, oDone}, 32'd0);
        checkOutput("rst_mid_push", {31'd0, oFifoPush}, 32'd0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(posedge iClock); #1;
        readHost(8'h0D, rd);
        checkOutput("rst_mid_r13", rd, 32'h0000_0077);
        readHost(8'h08, rd);
        checkOutput("rst_mid_r8", rd, 32'd100);
        readHost(8'h80, rd);
        checkOutput("rst_mid_ram", rd, enc(1'b0, DIV, 5'd13, 5'd8, 5'd9));
`ifdef RGS_DIV_EN
        runUntilDone("rerun", 37);
        readHost(8'h0D, rd);
        checkOutput("rerun_r13", rd, 32'd14);
`else
        runUntilDone("rerun", 5);
        readHost(8'h0D, rd);
        checkOutput("rerun_r13", rd, 32'h0000_0077);
`endif
        idleCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
